// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma keystroke sequencer.
// Holds ASCII constants, the FSM state encoding and the letter/one-hot helpers
// used on the input (fold/encode) and lamp (decode) sides.
package enigma_pkg;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_STEP,
    ST_SETTLE,
    ST_CAPTURE,
    ST_OUT
  } state_t;

  // True for 'A'-'Z' and 'a'-'z'.
  function automatic logic is_letter(input logic [7:0] ch);
    return ((ch >= ASCII_A) && (ch <= ASCII_Z)) ||
           ((ch >= ASCII_LA) && (ch <= ASCII_LZ));
  endfunction

  // Lower-case letters become upper case; everything else is untouched.
  function automatic logic [7:0] fold_upper(input logic [7:0] ch);
    if ((ch >= ASCII_LA) && (ch <= ASCII_LZ)) begin
      return ch - 8'h20;
    end
    return ch;
  endfunction

  // One-hot key vector for a letter (bit0 = 'A'); zero for non-letters.
  function automatic logic [25:0] letter2onehot(input logic [7:0] ch);
    logic [7:0] idx;
    if (!is_letter(ch)) begin
      return '0;
    end
    idx = fold_upper(ch) - ASCII_A;
    return 26'd1 << idx[4:0];
  endfunction

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [25:0] vec);
    return (vec != '0) && ((vec & (vec - 26'd1)) == '0);
  endfunction

  // Lamp vector back to ASCII; '?' when the vector is not one-hot.
  function automatic logic [7:0] onehot2letter(input logic [25:0] vec);
    logic [7:0] ch;
    logic [4:0] n;
    ch = ASCII_QMARK;
    n  = '0;
    for (int i = 0; i < 26; i++) begin
      if (vec[i]) begin
        n  = n + 5'd1;
        ch = ASCII_A + 8'(i);
      end
    end
    if (n != 5'd1) begin
      ch = ASCII_QMARK;
    end
    return ch;
  endfunction

endpackage

// File: rtl/enigma_group5.sv
// Five-letter group counter: counts emitted letters, flags when a space is due.
// Only compiled into the design when GROUP5_EN is defined.
// full is combinational from the count register; clr wins over inc.
`ifdef GROUP5_EN
module enigma_group5 (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic full
);

  logic [2:0] count;

  // Count letters 1..5; the letter emitted after a full group restarts at 1.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= 3'd0;
    end else if (inc) begin
      count <= (count == 3'd5) ? 3'd1 : count + 3'd1;
    end
  end

  assign full = (count == 3'd5);

endmodule
`endif

// File: rtl/enigma_ctrl.sv
// Keystroke sequencer: loads rotor settings, steps the rotors once per letter,
// drives the one-hot key into the rotor path and decodes the lamp vector to ASCII.
// Letter latency SETTLE+3 cycles from handshake, non-letters 1; OUT stalls on out_ready.
// Optional: define GROUP5_EN to insert a space before every sixth consecutive letter.
module enigma_ctrl
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter int SETTLE     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_load,
  input  logic [5*NUM_ROTORS-1:0]   cfg_offsets,
  input  logic [5*NUM_ROTORS-1:0]   cfg_rings,
  output logic                      cfg_ready,
  input  logic                      in_valid,
  input  logic [7:0]                in_char,
  output logic                      in_ready,
  output logic                      rot_set,
  output logic                      rot_step0,
  output logic                      rot_step,
  output logic [5*NUM_ROTORS-1:0]   rot_offset,
  output logic [5*NUM_ROTORS-1:0]   rot_ring,
  output logic [25:0]               path_in,
  input  logic [25:0]               path_out,
  output logic                      out_valid,
  output logic [7:0]                out_char,
  input  logic                      out_ready,
  output logic                      err
);

  // Settle counter runs SETTLE-1 down to 0, giving SETTLE cycles in ST_SETTLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state;
  logic [25:0] key_oh;
  logic [3:0]  settle_cnt;
  logic [7:0]  dec_char;
  logic        path_ok;

  assign dec_char  = onehot2letter(path_out);
  assign path_ok   = is_onehot(path_out);
  assign cfg_ready = (state == ST_IDLE);
  // A pending cfg_load takes the IDLE cycle, so the character must wait.
  assign in_ready  = (state == ST_IDLE) && !cfg_load;

`ifdef GROUP5_EN
  logic       letter_out;
  logic       space_pend;
  logic       grp_full;
  logic       grp_inc;
  logic       grp_clr;
  logic [7:0] hold_char;

  // The count advances on the handshake of the letter itself, not the space.
  assign grp_inc = (state == ST_OUT) && out_ready && letter_out && !space_pend;
  assign grp_clr = ((state == ST_OUT) && out_ready && !letter_out) ||
                   ((state == ST_IDLE) && cfg_load);

  enigma_group5 u_group5 (
    .clk   (clk),
    .reset (reset),
    .clr   (grp_clr),
    .inc   (grp_inc),
    .full  (grp_full)
  );
`endif

  // Sequencer FSM; every output is a register so the rotor stack sees clean pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      key_oh     <= '0;
      settle_cnt <= '0;
      rot_set    <= 1'b0;
      rot_step0  <= 1'b0;
      rot_step   <= 1'b0;
      rot_offset <= '0;
      rot_ring   <= '0;
      path_in    <= '0;
      out_valid  <= 1'b0;
      out_char   <= '0;
      err        <= 1'b0;
`ifdef GROUP5_EN
      letter_out <= 1'b0;
      space_pend <= 1'b0;
      hold_char  <= '0;
`endif
    end else begin
      rot_set   <= 1'b0;
      rot_step0 <= 1'b0;
      rot_step  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_load) begin
            rot_offset <= cfg_offsets;
            rot_ring   <= cfg_rings;
            rot_set    <= 1'b1;
            state      <= ST_SET;
          end else if (in_valid) begin
            if (is_letter(in_char)) begin
              key_oh    <= letter2onehot(in_char);
              rot_step0 <= 1'b1;
              rot_step  <= 1'b1;
              state     <= ST_STEP;
            end else begin
              // Non-letters bypass the rotors entirely.
              out_char  <= in_char;
              out_valid <= 1'b1;
              state     <= ST_OUT;
`ifdef GROUP5_EN
              letter_out <= 1'b0;
`endif
            end
          end
        end
        ST_SET: begin
          state <= ST_IDLE;
        end
        ST_STEP: begin
          // Rotors have stepped on this edge; present the key to the new positions.
          path_in    <= key_oh;
          settle_cnt <= SETTLE_LAST;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          path_in   <= '0;
          out_valid <= 1'b1;
          err       <= err | !path_ok;
          state     <= ST_OUT;
`ifdef GROUP5_EN
          letter_out <= 1'b1;
          if (grp_full) begin
            out_char   <= ASCII_SPACE;
            hold_char  <= dec_char;
            space_pend <= 1'b1;
          end else begin
            out_char <= dec_char;
          end
`else
          out_char <= dec_char;
`endif
        end
        ST_OUT: begin
          if (out_ready) begin
`ifdef GROUP5_EN
            if (space_pend) begin
              // Space accepted; the held letter follows in the same OUT visit.
              out_char   <= hold_char;
              space_pend <= 1'b0;
            end else begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end
`else
            out_valid <= 1'b0;
            state     <= ST_IDLE;
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_ctrl.sv
// Bench for enigma_ctrl: emulates rotors I-II-III with reflector B behind the
// path_in/path_out interface and checks the character stream against a
// string-level Enigma model, plus pulse counts, latency, stalls, err and reset.
module tb_enigma_ctrl;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [14:0] cfg_offsets;
  logic [14:0] cfg_rings;
  logic        cfg_ready;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        rot_set;
  logic        rot_step0;
  logic        rot_step;
  logic [14:0] rot_offset;
  logic [14:0] rot_ring;
  logic [25:0] path_in;
  logic [25:0] path_out;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_ready;
  logic        err;

  enigma_ctrl #(.NUM_ROTORS(3), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_offsets(cfg_offsets),
    .cfg_rings(cfg_rings), .cfg_ready(cfg_ready), .in_valid(in_valid),
    .in_char(in_char), .in_ready(in_ready), .rot_set(rot_set),
    .rot_step0(rot_step0), .rot_step(rot_step), .rot_offset(rot_offset),
    .rot_ring(rot_ring), .path_in(path_in), .path_out(path_out),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wiring tables: index 0 = fast rotor (III), 1 = II, 2 = I.
  int wf [3][26];
  int rf [26];

  initial begin
    string s;
    s = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    for (int i = 0; i < 26; i++) wf[0][i] = int'(s[i]) - 65;
    s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    for (int i = 0; i < 26; i++) wf[1][i] = int'(s[i]) - 65;
    s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    for (int i = 0; i < 26; i++) wf[2][i] = int'(s[i]) - 65;
    s = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    for (int i = 0; i < 26; i++) rf[i] = int'(s[i]) - 65;
  end

  // Classic Enigma substitution for letter c at positions p with rings r.
  function automatic int enc(input int c, input logic [14:0] p, input logic [14:0] r);
    int x, sh, t, j0;
    x = c;
    for (int k = 0; k < 3; k++) begin
      sh = (int'(p[5*k +: 5]) - int'(r[5*k +: 5]) + 52) % 26;
      x  = (wf[k][(x + sh) % 26] - sh + 26) % 26;
    end
    x = rf[x];
    for (int k = 2; k >= 0; k--) begin
      sh = (int'(p[5*k +: 5]) - int'(r[5*k +: 5]) + 52) % 26;
      t  = (x + sh) % 26;
      j0 = 0;
      for (int j = 0; j < 26; j++) if (wf[k][j] == t) j0 = j;
      x = (j0 - sh + 26) % 26;
    end
    return x;
  endfunction

  // Keypress stepping with the middle-rotor double step (notches V, E, Q).
  function automatic logic [14:0] stepped(input logic [14:0] p);
    int a, b, c;
    a = int'(p[4:0]); b = int'(p[9:5]); c = int'(p[14:10]);
    if (b == 4) begin
      b = (b + 1) % 26; c = (c + 1) % 26;
    end else if (a == 21) begin
      b = (b + 1) % 26;
    end
    a = (a + 1) % 26;
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic bit isl(input logic [7:0] c);
    return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
  endfunction

  // Rotor stack emulation driven by the DUT's set/step pulses.
  logic [14:0] dpos = '0;
  int          cyc = 0;
  int          step0_cnt = 0;
  int          step_diff = 0;
  logic        force_bad = 1'b0;
  logic [25:0] bad_val = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rot_step0) step0_cnt <= step0_cnt + 1;
    if (rot_step !== rot_step0) step_diff <= step_diff + 1;
    if (rot_set) dpos <= rot_offset;
    else if (rot_step0) dpos <= stepped(dpos);
  end

  always @(path_in or dpos or rot_ring or force_bad or bad_val) begin
    path_out = '0;
    for (int i = 0; i < 26; i++)
      if (path_in == (26'd1 << i)) path_out = 26'd1 << enc(i, dpos, rot_ring);
    if (force_bad) path_out = bad_val;
  end

  // Reference model state.
  logic [14:0] mp, mr;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx[$];
  logic        exp_err = 1'b0;
  int          letters = 0;
  int          t_hs = 0;
`ifdef GROUP5_EN
  int          grp = 0;
`endif

  task automatic model(input logic [7:0] c);
    logic [7:0] u, o;
    if (isl(c)) begin
      u  = (c >= 8'd97) ? c - 8'd32 : c;
      mp = stepped(mp);
      letters++;
      if (force_bad) begin
        o = 8'h3F;
        exp_err = 1'b1;
      end else begin
        o = 8'(65 + enc(int'(u) - 65, mp, mr));
      end
`ifdef GROUP5_EN
      if (grp == 5) begin
        exp_q.push_back(8'h20);
        grp = 1;
      end else begin
        grp++;
      end
`endif
      exp_q.push_back(o);
    end else begin
      exp_q.push_back(c);
`ifdef GROUP5_EN
      grp = 0;
`endif
    end
  endtask

  task automatic load_cfg(input logic [14:0] off, input logic [14:0] rng);
    @(negedge clk);
    cfg_load = 1'b1; cfg_offsets = off; cfg_rings = rng;
    in_valid = 1'b1; in_char = "Z";
    #1 check("cfg_in_ready", in_ready, 0);
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0; in_char = 8'h00;
    check("rot_set", rot_set, 1);
    check("rot_step_in_set", rot_step0, 0);
    check("rot_offset", rot_offset, off);
    check("rot_ring", rot_ring, rng);
    @(negedge clk);
    check("rot_set_width", rot_set, 0);
    mp = off; mr = rng;
`ifdef GROUP5_EN
    grp = 0;
`endif
  endtask

  task automatic collect(input int stall, input int lat);
    bit first = 1'b1;
    logic [7:0] e, held;
    int n, sb;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      if (!out_valid) begin
        check("out_timeout", out_valid, 1);
        exp_q.delete();
        return;
      end
      if (first) begin
        check("latency", 32'(cyc - t_hs), lat);
        first = 1'b0;
      end
      held = out_char; sb = step0_cnt;
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        check("stall_char", out_char, held);
        check("stall_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        check("stall_steps", step0_cnt, sb);
      end
      check("path_idle", path_in, 0);
      check("out_char", out_char, e);
      rx.push_back(out_char);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] c, input int stall);
    int n = 0;
    bit islet;
    islet = isl(c);
    model(c);
    @(negedge clk);
    in_valid = 1'b1; in_char = c;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("in_timeout", in_ready, 1);
      in_valid = 1'b0;
      exp_q.delete();
      return;
    end
    t_hs = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_char = 8'h00;
    collect(stall, islet ? SETTLE + 3 : 1);
    check("err", err, exp_err);
  endtask

  task automatic check_rx(input string tag, input string s);
    check({tag, "_len"}, rx.size(), s.len());
    for (int i = 0; i < s.len() && i < rx.size(); i++)
      check($sformatf("%s[%0d]", tag, i), rx[i], s[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    string s;
    int base, l0, seen;
    logic [14:0] off, rng;
    logic [7:0] c;
    logic [7:0] punct [8];
    punct = '{8'h20, 8'h30, 8'h39, 8'h2E, 8'h40, 8'h5B, 8'h60, 8'h7B};

    reset = 1'b1; cfg_load = 1'b0; cfg_offsets = '0; cfg_rings = '0;
    in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 0);
    check("rst_err", err, 0);
    check("rst_path_in", path_in, 0);
    check("rst_pulses", {rot_set, rot_step0, rot_step}, 0);
    check("rst_offset", rot_offset, 0);
    check("rst_ring", rot_ring, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // "AAAAA" -> "BDZGO"
    load_cfg(15'd0, 15'd0);
    rx.delete(); base = step0_cnt;
    for (int i = 0; i < 5; i++) send("A", 0);
    check_rx("aaaaa", "BDZGO");
    check("aaaaa_steps", 32'(step0_cnt - base), 5);

    // "a A" -> "B", space, "D"
    load_cfg(15'd0, 15'd0);
    rx.delete(); base = step0_cnt;
    send("a", 0); send(" ", 0); send("A", 0);
    check_rx("a_sp_a", "B D");
    check("a_sp_a_steps", 32'(step0_cnt - base), 2);

    // Long out_ready stall
    load_cfg(15'd0, 15'd0);
    rx.delete(); base = step0_cnt;
    send("A", 20);
    check_rx("stall", "B");
    check("stall_total_steps", 32'(step0_cnt - base), 1);

    // Non-one-hot lamp vectors give '?' and a sticky err
    load_cfg(15'd0, 15'd0);
    rx.delete();
    force_bad = 1'b1; bad_val = 26'h0000003;
    send("A", 0);
    bad_val = 26'h0;
    send("B", 0);
    force_bad = 1'b0;
    send("C", 2);
    check_rx("badpath", {"??", 8'(65 + enc(2, stepped(stepped(stepped(15'd0))), 15'd0))});
    check("err_sticky", err, 1);

    // Reset while the key is settling drops the character
    load_cfg(15'd0, 15'd0);
    @(negedge clk);
    in_valid = 1'b1; in_char = "A";
    @(negedge clk);
    in_valid = 1'b0; in_char = 8'h00;
    @(negedge clk);
    check("settle_path", path_in, 26'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_idle", cfg_ready, 1);
    check("rstmid_path", path_in, 0);
    check("rstmid_valid", out_valid, 0);
    exp_err = 1'b0;
    check("rstmid_err", err, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rstmid_dropped", seen, 0);

    // Grouping of seven letters
    load_cfg(15'd0, 15'd0);
    rx.delete();
    for (int i = 0; i < 7; i++) send("A", 0);
`ifdef GROUP5_EN
    s = "BDZGO WC";
`else
    s = "BDZGOWC";
`endif
    check_rx("group", s);

    // Randomized settings, characters and back-pressure
    for (int r = 0; r < 4; r++) begin
      off = {5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))};
      rng = {5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))};
      load_cfg(off, rng);
      base = step0_cnt; l0 = letters;
      for (int i = 0; i < 20; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: c = 8'(65 + $urandom_range(0, 25));
          6, 7:             c = 8'(97 + $urandom_range(0, 25));
          default:          c = punct[$urandom_range(0, 7)];
        endcase
        send(c, $urandom_range(0, 3));
      end
      check("rand_steps", 32'(step0_cnt - base), 32'(letters - l0));
    end

    check("step_pair", step_diff, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
